prob03p08_comb_gates_100_seq: RTL and testbench

PROB03P08_COMB_GATES_100_SEQ -- requirements
Module: prob03p08_comb_gates_100_seq

---
 rtl/prob03p08_comb_gates_100_seq.sv | 154 +++++++++++++++
 tb/tb_prob03p08_comb_gates_100_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prob03p08_comb_gates_100_seq.sv
// ---------------------------------------------------------------------------
// prob03p08_comb_gates_100_seq
//
// Purpose:
//   Computes the AND, NAND, OR and NOR reductions of a 100-bit operand.
//   The operand is consumed 10 bits per clock, so an accepted operand takes
//   ten REDUCE cycles before the results are presented. A valid/ready
//   handshake is used on both the input and the output side.
//
// Configuration:
//   PROB03P08_EARLY_TERM_EN - when defined, the reduction stops as soon as
//   the running AND is 0 and the running OR is 1, because no later chunk can
//   change either result. When undefined, every operand takes exactly ten
//   REDUCE cycles.
//
// Ports:
//   clk      in   1    rising-edge clock
//   reset_n  in   1    asynchronous active-low reset
//   in_val   in   1    operand request
//   in_rdy   out  1    block is idle and will accept an operand
//   in_      in   100  operand, sampled on the accept edge
//   out_val  out  1    results valid
//   out_rdy  in   1    consumer accepts the results
//   out_and  out  1    AND reduction of the accepted operand
//   out_nand out  1    complement of out_and
//   out_or   out  1    OR reduction of the accepted operand
//   out_nor  out  1    complement of out_or
//   busy     out  1    block is not in IDLE
// ---------------------------------------------------------------------------
module prob03p08_comb_gates_100_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [99:0] in_,
  output logic        out_val,
  input  logic        out_rdy,
  output logic        out_and,
  output logic        out_nand,
  output logic        out_or,
  output logic        out_nor,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CHUNK = 4'd9;

  state_t      state;
  logic [99:0] opnd;
  logic [3:0]  cnt;
  logic        acc_and;
  logic        acc_or;

  logic [9:0]  chunk;
  logic        next_and;
  logic        next_or;
  logic        finish;

  // Select the 10-bit slice for the current chunk index; chunk 0 is the
  // least significant ten bits of the operand.
  always_comb begin
    chunk = 10'd0;
    case (cnt)
      4'd0:    chunk = opnd[9:0];
      4'd1:    chunk = opnd[19:10];
      4'd2:    chunk = opnd[29:20];
      4'd3:    chunk = opnd[39:30];
      4'd4:    chunk = opnd[49:40];
      4'd5:    chunk = opnd[59:50];
      4'd6:    chunk = opnd[69:60];
      4'd7:    chunk = opnd[79:70];
      4'd8:    chunk = opnd[89:80];
      4'd9:    chunk = opnd[99:90];
      default: chunk = 10'd0;
    endcase
  end

  // Accumulator values after folding in the current chunk, and the decision
  // whether this REDUCE edge is the last one for the operand.
  always_comb begin
    next_and = acc_and & (&chunk);
    next_or  = acc_or  | (|chunk);
    finish   = (cnt == LAST_CHUNK);
`ifdef PROB03P08_EARLY_TERM_EN
    // Once AND has dropped and OR has risen, the remaining chunks are moot.
    if (!next_and && next_or) begin
      finish = 1'b1;
    end
`endif
  end

  // Control FSM together with the operand, accumulator, counter and result
  // registers. Results only change on the edge that enters DONE, so they
  // stay stable through DONE and keep their values after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      opnd    <= '0;
      cnt     <= 4'd0;
      acc_and <= 1'b1;
      acc_or  <= 1'b0;
      out_and <= 1'b0;
      out_or  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            opnd    <= in_;
            acc_and <= 1'b1;
            acc_or  <= 1'b0;
            cnt     <= 4'd0;
            state   <= REDUCE;
          end
        end
        REDUCE: begin
          acc_and <= next_and;
          acc_or  <= next_or;
          if (finish) begin
            // Counter parks at zero so it never walks past the last chunk.
            cnt     <= 4'd0;
            out_and <= next_and;
            out_or  <= next_or;
            state   <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Handshake flags decode the state directly; the complemented results are
  // derived from the result registers so they can never disagree with them.
  assign in_rdy   = (state == IDLE);
  assign out_val  = (state == DONE);
  assign busy     = (state != IDLE);
  assign out_nand = ~out_and;
  assign out_nor  = ~out_or;

endmodule

// File: tb/tb_prob03p08_comb_gates_100_seq.sv
// ---------------------------------------------------------------------------
// tb_prob03p08_comb_gates_100_seq
//
// Directed and randomised self-checking bench for the 100-bit reduction
// block. Expected results come from SystemVerilog reduction operators on the
// operand the bench drove; expected latency comes from a chunk-wise model
// that honours PROB03P08_EARLY_TERM_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_prob03p08_comb_gates_100_seq;

  logic        clk;
  logic        reset_n;
  logic        in_val;
  logic        in_rdy;
  logic [99:0] in_;
  logic        out_val;
  logic        out_rdy;
  logic        out_and;
  logic        out_nand;
  logic        out_or;
  logic        out_nor;
  logic        busy;

  int checkCount;
  int errorCount;

  prob03p08_comb_gates_100_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_     (in_),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_and (out_and),
    .out_nand(out_nand),
    .out_or  (out_or),
    .out_nor (out_nor),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Number of edges from accept to out_val for a given operand.
  function automatic int expLatency(input logic [99:0] op);
    int lat;
    logic a;
    logic o;
    logic [99:0] sh;
    lat = 10;
`ifdef PROB03P08_EARLY_TERM_EN
    a  = 1'b1;
    o  = 1'b0;
    sh = op;
    for (int c = 0; c < 10; c++) begin
      a  = a & (&sh[9:0]);
      o  = o | (|sh[9:0]);
      sh = sh >> 10;
      if (!a && o) begin
        lat = c + 1;
        break;
      end
    end
`else
    a  = 1'b0;
    o  = 1'b0;
    sh = op;
`endif
    return lat;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_rdy"},   in_rdy,   1);
    checkOutput({tag, "_out_val"},  out_val,  0);
    checkOutput({tag, "_busy"},     busy,     0);
    checkOutput({tag, "_out_and"},  out_and,  0);
    checkOutput({tag, "_out_nand"}, out_nand, 1);
    checkOutput({tag, "_out_or"},   out_or,   0);
    checkOutput({tag, "_out_nor"},  out_nor,  1);
  endtask

  task automatic checkResults(input string tag, input logic [99:0] op);
    checkOutput({tag, "_and"},  out_and,  &op);
    checkOutput({tag, "_nand"}, out_nand, ~&op);
    checkOutput({tag, "_or"},   out_or,   |op);
    checkOutput({tag, "_nor"},  out_nor,  ~|op);
  endtask

  // Runs one operand through the block. in_val stays high the whole time so
  // the block must ignore it outside IDLE; in_ is scrambled after the accept
  // edge to prove the operand was latched. 'hold' cycles of out_rdy low are
  // spent in DONE before the output handshake.
  task automatic applyStimulus(input string tag, input logic [99:0] op,
                               input int hold);
    int waitCycles;
    int lat;
    waitCycles = 0;
    while (!in_rdy && waitCycles < 30) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!in_rdy) begin
      checkOutput({tag, "_rdy_timeout"}, in_rdy, 1);
    end
    in_val  = 1'b1;
    in_     = op;
    out_rdy = (hold == 0);
    @(posedge clk); #1;
    in_ = ~op;
    checkOutput({tag, "_busy_accept"}, busy, 1);
    lat = 0;
    while (!out_val && lat < 25) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, expLatency(op));
    checkOutput({tag, "_in_rdy_done"}, in_rdy, 0);
    checkResults(tag, op);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_val"}, out_val, 1);
      checkOutput({tag, "_hold_rdy"}, in_rdy, 0);
      checkResults({tag, "_hold"}, op);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_post_val"}, out_val, 0);
    checkOutput({tag, "_post_rdy"}, in_rdy, 1);
    checkResults({tag, "_post"}, op);
    in_val = 1'b0;
  endtask

  logic [99:0] op;
  logic [127:0] wide;
  int sawVal;

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset_n = 1'b0;
    in_val  = 1'b0;
    in_     = '0;
    out_rdy = 1'b0;

    #1;
    checkResetValues("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkResetValues("reset_hold");
    reset_n = 1'b1;

    // Directed operands.
    applyStimulus("ones", {100{1'b1}}, 0);
    applyStimulus("zeros", '0, 0);
    op = {100{1'b1}};
    op[0] = 1'b0;
    applyStimulus("bit0_low", op, 0);
    op = '0;
    op[99] = 1'b1;
    applyStimulus("bit99_hold", op, 5);

    // Abort a reduction at cnt=4 with a reset pulse.
    op = {100{1'b1}};
    in_val  = 1'b1;
    in_     = op;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    checkResetValues("abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    sawVal = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_val) sawVal = 1;
    end
    checkOutput("abort_no_out_val", sawVal, 0);
    checkOutput("abort_idle_busy", busy, 0);
    applyStimulus("after_abort", '0, 0);

    // Back-to-back randomised operands, with some dense patterns mixed in so
    // the AND reduction is exercised in both directions.
    for (int i = 0; i < 1000; i++) begin
      wide = {$urandom, $urandom, $urandom, $urandom};
      op = wide[99:0];
      case (i % 8)
        0: op = {100{1'b1}};
        1: begin
          op = {100{1'b1}};
          op[$urandom_range(99, 0)] = 1'b0;
        end
        2: op = '0;
        3: begin
          op = '0;
          op[$urandom_range(99, 0)] = 1'b1;
        end
        default: ;
      endcase
      applyStimulus("rand", op, (i % 16 == 5) ? 2 : 0);
      in_val = 1'b1;
    end
    in_val = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global cycle guard so the run always terminates.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
